// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: controller state encoding, register-index width
// and the bit layout of the WB control bundle.
package pipeline_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam int WB_REGWRITE = 3;
  localparam int WB_MEMTOREG = 2;
  localparam int WB_PCTOREG  = 1;
  localparam int WB_HALT     = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage register controls and
// performance counters out. The controller uses the slave modport.
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             idex_memread;
  logic [REG_W-1:0] idex_dstreg;
  logic [REG_W-1:0] ifid_src1;
  logic [REG_W-1:0] ifid_src2;
  logic             ifid_use1;
  logic             ifid_use2;
  logic             branch_taken;
  logic             halt_id;
  logic             wb_halt;
  logic             imem_busy;
  logic             dmem_busy;
  logic             pc_wen;
  logic             ifid_wen;
  logic             ifid_nop;
  logic             idex_wen;
  logic             idex_nop;
  logic             exmem_wen;
  logic             memwb_nop;
  logic             imem_abort;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output idex_memread, idex_dstreg, ifid_src1, ifid_src2, ifid_use1, ifid_use2,
           branch_taken, halt_id, wb_halt, imem_busy, dmem_busy,
    input  pc_wen, ifid_wen, ifid_nop, idex_wen, idex_nop, exmem_wen, memwb_nop,
           imem_abort, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  idex_memread, idex_dstreg, ifid_src1, ifid_src2, ifid_use1, ifid_use2,
           branch_taken, halt_id, wb_halt, imem_busy, dmem_busy,
    output pc_wen, ifid_wen, ifid_nop, idex_wen, idex_nop, exmem_wen, memwb_nop,
           imem_abort, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Register 0 is hardwired and never causes a hazard.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_dstreg,
  input  logic [REG_W-1:0] ifid_src1,
  input  logic [REG_W-1:0] ifid_src2,
  input  logic             ifid_use1,
  input  logic             ifid_use2,
  output logic             lu
);
  logic [REG_W-1:0] src [2];
  logic [1:0]       use_src;
  logic [1:0]       match;

  assign src[0]  = ifid_src1;
  assign src[1]  = ifid_src2;
  assign use_src = {ifid_use2, ifid_use1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign match[gi] = use_src[gi] && (src[gi] == idex_dstreg);
  end

  assign lu = idex_memread && (idex_dstreg != '0) && (|match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline, with saturating
// stall and flush counters. Controls are combinational from state and inputs.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hc
);
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic             lu;
  logic             flush_evt;
  logic             pc_wen, ifid_wen, ifid_nop, idex_wen, idex_nop;
  logic             exmem_wen, memwb_nop, imem_abort, halted;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_detect u_hazard_detect (
    .idex_memread (hc.idex_memread),
    .idex_dstreg  (hc.idex_dstreg),
    .ifid_src1    (hc.ifid_src1),
    .ifid_src2    (hc.ifid_src2),
    .ifid_use1    (hc.ifid_use1),
    .ifid_use2    (hc.ifid_use2),
    .lu           (lu)
  );

  always_comb begin
    pc_wen     = 1'b1;
    ifid_wen   = 1'b1;
    ifid_nop   = 1'b0;
    idex_wen   = 1'b1;
    idex_nop   = 1'b0;
    exmem_wen  = 1'b1;
    memwb_nop  = 1'b0;
    imem_abort = 1'b0;
    halted     = 1'b0;
    flush_evt  = 1'b0;
    state_next = state_reg;
    if (!rst) begin
      case (state_reg)
        RUN: begin
          // A data-memory freeze holds every older input; nothing else acts.
          if (hc.dmem_busy) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            memwb_nop = 1'b1;
          end else if (lu) begin
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
            idex_nop = 1'b1;
          end else if (hc.branch_taken) begin
            ifid_nop   = 1'b1;
            imem_abort = hc.imem_busy;
            flush_evt  = 1'b1;
          end else if (hc.imem_busy) begin
            pc_wen   = 1'b0;
            ifid_nop = 1'b1;
          end else if (hc.halt_id) begin
            pc_wen     = 1'b0;
            ifid_nop   = 1'b1;
            state_next = HALTING;
          end
          if (hc.wb_halt) state_next = HALTED;
        end
        HALTING: begin
          if (hc.dmem_busy) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            memwb_nop = 1'b1;
          end else begin
            pc_wen   = 1'b0;
            ifid_nop = 1'b1;
          end
          if (hc.wb_halt) state_next = HALTED;
        end
        HALTED: begin
          pc_wen    = 1'b0;
          ifid_wen  = 1'b0;
          idex_wen  = 1'b0;
          exmem_wen = 1'b0;
          memwb_nop = 1'b1;
          halted    = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (!pc_wen && state_reg != HALTED) stall_cnt_reg <= sat_inc(stall_cnt_reg);
      if (flush_evt) flush_cnt_reg <= sat_inc(flush_cnt_reg);
    end
  end

  assign hc.pc_wen     = pc_wen;
  assign hc.ifid_wen   = ifid_wen;
  assign hc.ifid_nop   = ifid_nop;
  assign hc.idex_wen   = idex_wen;
  assign hc.idex_nop   = idex_nop;
  assign hc.exmem_wen  = exmem_wen;
  assign hc.memwb_nop  = memwb_nop;
  assign hc.imem_abort = imem_abort;
  assign hc.halted     = halted;
  assign hc.stall_cnt  = stall_cnt_reg;
  assign hc.flush_cnt  = flush_cnt_reg;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random checks of pipeline_hazard_ctrl against a cycle model
// built from the hazard priority rules, with 4-bit counters to reach saturation.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hc ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hc  (hc)
  );

  always #5 clk = ~clk;

  // Model state: mode 0 = running, 1 = draining after HLT, 2 = stopped.
  int  m_mode  = 0;
  int  m_stall = 0;
  int  m_flush = 0;
  bit  m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected controls packed as {pc,ifid_wen,ifid_nop,idex_wen,idex_nop,exmem_wen,memwb_nop,abort,halted}.
  function automatic logic [8:0] model_ctrl(output int nxt_mode, output bit st, output bit fl);
    bit lu;
    logic [8:0] e;
    e = 9'b1_1_0_1_0_1_0_0_0;
    nxt_mode = m_mode;
    fl = 1'b0;
    lu = hc.idex_memread && hc.idex_dstreg != 0 &&
         ((hc.ifid_use1 && hc.ifid_src1 == hc.idex_dstreg) ||
          (hc.ifid_use2 && hc.ifid_src2 == hc.idex_dstreg));
    if (rst) nxt_mode = 0;
    else if (m_mode == 2) e = 9'b0_0_0_0_0_0_1_0_1;
    else begin
      if (hc.dmem_busy) e = 9'b0_0_0_0_0_0_1_0_0;
      else if (m_mode == 1) e = 9'b0_1_1_1_0_1_0_0_0;
      else if (lu) e = 9'b0_0_0_1_1_1_0_0_0;
      else if (hc.branch_taken) begin
        e = {7'b1_1_1_1_0_1_0, hc.imem_busy, 1'b0};
        fl = 1'b1;
      end else if (hc.imem_busy) e = 9'b0_1_1_1_0_1_0_0_0;
      else if (hc.halt_id) begin
        e = 9'b0_1_1_1_0_1_0_0_0;
        nxt_mode = 1;
      end
      if (hc.wb_halt) nxt_mode = 2;
    end
    st = !rst && m_mode != 2 && e[8] == 1'b0;
    return e;
  endfunction

  task automatic tick();
    logic [8:0] e;
    int nm;
    bit st, fl;
    @(negedge clk);
    e = model_ctrl(nm, st, fl);
    check("ctrl", {hc.pc_wen, hc.ifid_wen, hc.ifid_nop, hc.idex_wen, hc.idex_nop,
                   hc.exmem_wen, hc.memwb_nop, hc.imem_abort, hc.halted}, {23'd0, e});
    if (m_known) begin
      check("stall_cnt", hc.stall_cnt, m_stall);
      check("flush_cnt", hc.flush_cnt, m_flush);
    end
    @(posedge clk);
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
      m_known = 1'b1;
    end else begin
      if (st && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
    end
    m_mode = nm;
    #1;
  endtask

  task automatic idle();
    hc.idex_memread = 0; hc.idex_dstreg = 0; hc.ifid_src1 = 0; hc.ifid_src2 = 0;
    hc.ifid_use1 = 0; hc.ifid_use2 = 0; hc.branch_taken = 0; hc.halt_id = 0;
    hc.wb_halt = 0; hc.imem_busy = 0; hc.dmem_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] r);
    hc.idex_memread = 1; hc.idex_dstreg = r; hc.ifid_src1 = r; hc.ifid_use1 = 1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Load-use: one bubble, then free flow; r0 never stalls.
    set_lu(4'h3);
    #1 check("lu_stall", {hc.pc_wen, hc.ifid_wen, hc.idex_nop}, 3'b001);
    tick();
    idle();
    tick();
    check("lu_cnt", hc.stall_cnt, 1);
    set_lu(4'h0);
    tick();
    idle();
    tick();
    check("lu_r0_cnt", hc.stall_cnt, 1);

    // Branch flush, then branch during an instruction miss.
    hc.branch_taken = 1;
    tick();
    hc.imem_busy = 1;
    #1 check("br_abort", hc.imem_abort, 1'b1);
    tick();
    idle();
    tick();
    check("br_cnt", hc.flush_cnt, 2);

    // Data miss for five cycles with lu and branch pending.
    do_reset();
    hc.dmem_busy = 1; hc.branch_taken = 1; set_lu(4'h5);
    repeat (5) tick();
    hc.dmem_busy = 0;
    #1 check("dm_lu", {hc.pc_wen, hc.idex_nop, hc.memwb_nop}, 3'b010);
    tick();
    idle();
    tick();
    check("dm_stall", hc.stall_cnt, 6);
    check("dm_flush", hc.flush_cnt, 0);

    // Halt drain with a branch ignored, then wb_halt stops the core.
    do_reset();
    hc.halt_id = 1;
    tick();
    hc.halt_id = 0; hc.branch_taken = 1;
    tick();
    tick();
    hc.wb_halt = 1;
    tick();
    idle();
    #1 check("halted", {hc.halted, hc.pc_wen, hc.exmem_wen}, 3'b100);
    check("halt_flush", hc.flush_cnt, 0);
    tick();
    tick();

    // Reset out of HALTED and out of a data stall.
    do_reset();
    #1 check("rst_halted", {hc.halted, hc.pc_wen, hc.stall_cnt, hc.flush_cnt}, {1'b0, 1'b1, 8'h00});
    hc.dmem_busy = 1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; hc.dmem_busy = 0;
    #1 check("rst_dmem", {hc.pc_wen, hc.exmem_wen, hc.stall_cnt}, {2'b11, 4'h0});

    // Stall counter saturation.
    hc.imem_busy = 1;
    repeat (20) tick();
    idle();
    tick();
    check("sat", hc.stall_cnt, 4'hF);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      hc.idex_memread = ($urandom_range(0, 2) == 0);
      hc.idex_dstreg  = 4'($urandom_range(0, 3));
      hc.ifid_src1    = 4'($urandom_range(0, 3));
      hc.ifid_src2    = 4'($urandom_range(0, 3));
      hc.ifid_use1    = 1'($urandom_range(0, 1));
      hc.ifid_use2    = 1'($urandom_range(0, 1));
      hc.branch_taken = ($urandom_range(0, 4) == 0);
      hc.halt_id      = ($urandom_range(0, 9) == 0);
      hc.wb_halt      = ($urandom_range(0, 24) == 0);
      hc.imem_busy    = ($urandom_range(0, 3) == 0);
      hc.dmem_busy    = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/halt sequencer for the 5-stage, 16-bit, 16-register pipeline.
- Drives write-enable and nop (bubble) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from these inputs:
  - load-use hazards
  - ID-stage branch resolution
  - instruction/data memory busy
  - halt
- Counts stall and flush events for performance reporting.

Parameters:
- CNT_W, 16, width of the performance counters (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- idex_memread  in  1  instruction in EX is a load
- idex_dstreg  in  4  destination register of instruction in EX
- ifid_src1  in  4  source register 1 of instruction in ID
- ifid_src2  in  4  source register 2 of instruction in ID
- ifid_use1  in  1  ID instruction reads src1
- ifid_use2  in  1  ID instruction reads src2
- branch_taken  in  1  ID resolved a taken branch/jump
- halt_id  in  1  HLT decoded in ID
- wb_halt  in  1  Halt bit out of MEM/WB
- imem_busy  in  1  instruction fetch not complete this cycle
- dmem_busy  in  1  data access in MEM not complete this cycle
- pc_wen  out  1  PC write enable
- ifid_wen  out  1  IF/ID write enable
- ifid_nop  out  1  load bubble into IF/ID
- idex_wen  out  1  ID/EX write enable
- idex_nop  out  1  load bubble into ID/EX
- exmem_wen  out  1  EX/MEM write enable
- memwb_nop  out  1  load bubble into MEM/WB
- imem_abort  out  1  cancel in-flight fetch
- halted  out  1  processor stopped
- stall_cnt  out  CNT_W  cycles with pc_wen=0 while not HALTED
- flush_cnt  out  CNT_W  branch flushes performed

Behaviour:
- FSM states:
  - RUN: normal operation.
  - HALTING: HLT seen in ID, draining.
  - HALTED: stopped.
- Reset (rst high at a clk edge):
  - state goes to RUN; counters and halted go to 0.
  - While rst is high, outputs take the RUN no-hazard values: all wen=1, all nop=0, imem_abort=0.
  - Reset mid-stall or mid-halt abandons that state immediately.
- Load-use hazard: lu = idex_memread & idex_dstreg!=0 & ((ifid_use1 & ifid_src1==idex_dstreg) | (ifid_use2 & ifid_src2==idex_dstreg)).
- RUN priority, highest first:
  1. dmem_busy: pc_wen=ifid_wen=idex_wen=exmem_wen=0; memwb_nop=1, so WB does not re-commit. Held for every busy cycle; resumes the cycle after busy drops.
  2. lu: pc_wen=0, ifid_wen=0, idex_nop=1. Exactly a 1-cycle bubble; the next cycle re-evaluates with the load in MEM.
  3. branch_taken: pc_wen=1 (redirect), ifid_nop=1; flush_cnt+1. If imem_busy is also high, imem_abort=1 for that cycle.
  4. imem_busy: pc_wen=0, ifid_nop=1 (IF/ID written with bubble); downstream advances.
  5. halt_id: pc_wen=0, ifid_nop=1; next state HALTING.
  6. Otherwise all enables 1, all nops 0.
- Under dmem_busy, a simultaneous lu, branch or halt is not acted on. The inputs are held by the frozen registers and are re-evaluated when busy drops.
- HALTING:
  - pc_wen=0, ifid_nop=1 every cycle; downstream advances.
  - dmem_busy freeze still applies.
  - wb_halt=1 moves to HALTED next cycle.
  - branch_taken, lu and imem_busy are ignored.
- HALTED:
  - all wen=0, memwb_nop=1, halted=1.
  - Leaves only by rst.
- wb_halt in RUN (cannot occur legally) is also treated as a move to HALTED.
- stall_cnt increments in every non-reset cycle with pc_wen=0 and state!=HALTED.
- Both counters saturate at all-ones; no wrap.
- Outputs are combinational from state and inputs. The only registers are state and the counters; no input-to-output register latency.

Decomposition:
- Shared package (pipeline_pkg):
  - state encoding constants RUN=2'd0, HALTING=2'd1, HALTED=2'd2
  - register-index width 4
  - WB-bundle bit positions (RegWrite=3, MemtoReg=2, PCtoReg=1, Halt=0)
- One sub-module: hazard_detect. Combinational lu computation, reusable by the forwarding unit.
- Counters use a local saturating increment; no separate module.

Test Plan:
- Load-use: idex_memread=1, idex_dstreg=4'h3, ifid_src1=4'h3, ifid_use1=1 -> one cycle of pc_wen=0, ifid_wen=0, idex_nop=1; next cycle (memread=0) all enables 1; stall_cnt=1. Repeat with dstreg=0 -> no stall.
- Branch flush: branch_taken=1 -> pc_wen=1, ifid_nop=1, flush_cnt=1. Branch_taken with imem_busy=1 -> additionally imem_abort=1.
- Dmem miss: dmem_busy=1 for 5 cycles while lu=1 and branch_taken=1 -> for 5 cycles pc/ifid/idex/exmem wen=0 and memwb_nop=1, no flush counted; then lu is handled on cycle 6; stall_cnt=6.
- Halt: halt_id=1 -> HALTING with ifid_nop=1. wb_halt pulses 3 cycles later -> halted=1 on the next cycle with all wen=0. Branch_taken during HALTING is ignored.
- Reset: assert rst during HALTED and during a dmem stall -> the next cycle shows halted=0, counters 0, all wen=1.
- Saturation: with CNT_W=4, hold imem_busy for 20 cycles -> stall_cnt stops at 4'hF.
